find_one_idx: RTL and testbench
===============================

# find_one_idx

Registered first-four-set-bits locator. Each cycle it scans a 128-bit word from bit 0 upward and reports the bit positions of the first four 1s, plus how many were found (saturating at 4). It sits in the datapath wherever sparse bit-vectors such as hit masks or valid maps must be turned into up to four indices per cycle. The result is registered, giving one cycle of latency.

## Interface
Parameters:
- DATA_W, 128: input word width. Fixed; other values are unsupported.
- IDX_W, 7: index width, equal to clog2(DATA_W).
- MAX_FOUND, 4: number of indices reported.

Ports:
- i_clk  input  1  the single clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_data  input  128  word to scan; bit 0 is scanned first.
- o_idx1  output  7  position of the lowest set bit.
- o_idx2  output  7  position of the 2nd-lowest set bit.
- o_idx3  output  7  position of the 3rd-lowest set bit.
- o_idx4  output  7  position of the 4th-lowest set bit.
- o_num_found  output  3  count of set bits, saturated to 4 (range 0..4).

## Operation
- Let popcount(i_data) = P.
- o_num_found = min(P, 4).
- The k-th index output (k = 1..4) is the bit position of the k-th set bit, counting up from bit 0. It is valid when k ≤ o_num_found.
- Any index output with k > o_num_found is forced to 7'd0, never left stale or X.
- Valid indices are strictly increasing: idx1 < idx2 < idx3 < idx4 within the valid range.
- Set bits beyond the fourth are ignored. They have no effect on any output.
- Recommended core algorithm is a cascade of four stages:
  - Each stage takes the current word w and outputs the priority-encoded index of its lowest 1, plus a found flag.
  - Each stage passes w & (w − 1) to the next stage.
  - An equivalent parallel-prefix implementation is acceptable if the outputs are identical.
- There is no handshake. i_data is sampled every cycle and the outputs always reflect the word sampled on the previous edge.

## Timing
- Latency is exactly 1 cycle. i_data present before rising edge N appears on all outputs after edge N.
- Throughput is one new word per cycle.
- All five outputs come directly from flops, with no combinational path from i_data to any output.
- Reset:
  - When i_rst_n is low, all outputs go to 0 immediately, without waiting for a clock edge.
  - Outputs stay at 0 while i_rst_n is held low.
  - The first capture occurs on the first rising edge after deassertion.
- If reset is asserted mid-stream, the in-flight result is discarded, with no residual output after release.
- Boundary behaviour:
  - i_data = 0 gives all outputs 0. A found index of 0 is distinguishable from "not found" only through o_num_found.
  - i_data = all-ones gives indices 0, 1, 2, 3 and num = 4.
  - Bit 127 must be reachable: a word with only bit 127 set gives idx1 = 127 and num = 1.
- The combinational path is four cascaded 128-bit priority encoders and must close at the target clock. Pipelining is not permitted, because latency is fixed at 1.

## Structure
- Shared package holds DATA_W, IDX_W and MAX_FOUND, plus the NUM_W = 3 width constant.
- One sub-module, lsb_one_enc:
  - Purely combinational.
  - Input w[127:0]; outputs idx[6:0], found, and w_next = w & (w − 1).
  - idx = 0 when w = 0.
  - Instantiated four times in series.
- The top level contains the four instances, the saturating count derived from the found flags, and the output registers.

## Test plan
- Reset: hold i_rst_n low with i_data = all-ones → all outputs 0. Release, apply 128'h0 → outputs remain 0 with num = 0.
- Sparse word: bits {3, 40, 77, 127} set → idx 3, 40, 77, 127; num = 4; all appear exactly one cycle after the input is applied.
- Fewer than four: bits {5, 100} set → idx1 = 5, idx2 = 100, idx3 = 0, idx4 = 0, num = 2. Single bit 127 → idx1 = 127, num = 1.
- Saturation: all-ones → 0, 1, 2, 3 with num = 4. 128'hF000…0 (bits 124–127) → 124, 125, 126, 127 with num = 4.
- Back-to-back: change i_data every cycle for 16 cycles, including random dense and sparse patterns → each output matches a software model of the previous cycle's input, with no cycle skipped.
- Mid-stream reset: assert i_rst_n asynchronously between edges while the outputs are nonzero → outputs drop to 0 without a clock edge and recover correctly after release.

Source files
------------

// File: rtl/find_one_idx_pkg.sv
// Shared widths and helpers for the first-four-set-bits locator.
package find_one_idx_pkg;

  localparam int unsigned DATA_W    = 128;
  localparam int unsigned IDX_W     = 7;
  localparam int unsigned MAX_FOUND = 4;
  localparam int unsigned NUM_W     = 3;

  // Found flags are monotone (stage k only fires if stage k-1 did), so the
  // plain sum is already the count saturated at MAX_FOUND.
  function automatic logic [NUM_W-1:0] count_found(input logic [MAX_FOUND-1:0] f);
    logic [NUM_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_FOUND; i++) begin
      cnt = cnt + NUM_W'(f[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/find_one_idx_lsb_one_enc.sv
// Combinational lowest-set-bit encoder; also strips that bit for the next stage.
module lsb_one_enc
  import find_one_idx_pkg::*;
(
  input  logic [DATA_W-1:0] w,
  output logic [IDX_W-1:0]  idx,
  output logic              found,
  output logic [DATA_W-1:0] w_next
);

  logic [DATA_W-1:0] lsb;

  // Isolate the lowest 1 as a one-hot word, then OR-encode its position;
  // this keeps the encoder a flat OR tree instead of a 128-deep priority chain.
  assign lsb    = w & (~w + DATA_W'(1));
  assign w_next = w & (w - DATA_W'(1));
  assign found  = |w;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (lsb[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/find_one_idx.sv
// Registered locator of the first four set bits of a 128-bit word, 1-cycle latency.
module find_one_idx
  import find_one_idx_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  output logic [IDX_W-1:0]  o_idx1,
  output logic [IDX_W-1:0]  o_idx2,
  output logic [IDX_W-1:0]  o_idx3,
  output logic [IDX_W-1:0]  o_idx4,
  output logic [NUM_W-1:0]  o_num_found
);

  logic [DATA_W-1:0]    w_chain [MAX_FOUND+1];
  logic [IDX_W-1:0]     idx     [MAX_FOUND];
  logic [MAX_FOUND-1:0] found;
  logic [DATA_W-1:0]    tail_unused;

  assign w_chain[0]  = i_data;
  assign tail_unused = w_chain[MAX_FOUND];

  for (genvar k = 0; k < MAX_FOUND; k++) begin : g_stage
    lsb_one_enc u_enc (
      .w      (w_chain[k]),
      .idx    (idx[k]),
      .found  (found[k]),
      .w_next (w_chain[k+1])
    );
  end

  // A stage that sees an empty word already reports index 0, so no extra masking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_idx1      <= '0;
      o_idx2      <= '0;
      o_idx3      <= '0;
      o_idx4      <= '0;
      o_num_found <= '0;
    end else begin
      o_idx1      <= idx[0];
      o_idx2      <= idx[1];
      o_idx3      <= idx[2];
      o_idx4      <= idx[3];
      o_num_found <= count_found(found);
    end
  end

endmodule

// File: tb/tb_find_one_idx.sv
// Directed table plus multi-cycle sequences for the first-four-set-bits locator.
module tb_find_one_idx;

  logic         clk;
  logic         rst_n;
  logic [127:0] data;
  logic [6:0]   idx1, idx2, idx3, idx4;
  logic [2:0]   num;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [127:0] data;
    logic [6:0]   e1, e2, e3, e4;
    logic [2:0]   en;
  } vec_t;

  vec_t vecs [9];

  find_one_idx dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data      (data),
    .o_idx1      (idx1),
    .o_idx2      (idx2),
    .o_idx3      (idx3),
    .o_idx4      (idx4),
    .o_num_found (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] e1, input logic [6:0] e2,
                         input logic [6:0] e3, input logic [6:0] e4, input logic [2:0] en);
    chk({tag, ".idx1"}, int'(idx1), int'(e1));
    chk({tag, ".idx2"}, int'(idx2), int'(e2));
    chk({tag, ".idx3"}, int'(idx3), int'(e3));
    chk({tag, ".idx4"}, int'(idx4), int'(e4));
    chk({tag, ".num"},  int'(num),  int'(en));
  endtask

  // Straightforward bit-walk reference, independent of the RTL's bit tricks.
  task automatic model(input logic [127:0] d, output logic [6:0] r1, output logic [6:0] r2,
                       output logic [6:0] r3, output logic [6:0] r4, output logic [2:0] rn);
    int n;
    logic [6:0] r [4];
    n = 0;
    for (int i = 0; i < 4; i++) r[i] = '0;
    for (int b = 0; b < 128; b++) begin
      if (d[b] && n < 4) begin
        r[n] = 7'(b);
        n++;
      end
    end
    r1 = r[0]; r2 = r[1]; r3 = r[2]; r4 = r[3]; rn = 3'(n);
  endtask

  function automatic logic [127:0] bit_at(input int b);
    logic [127:0] one;
    one = 128'd1;
    return one << b;
  endfunction

  initial begin
    logic [127:0] prev, ones;
    logic [6:0]   m1, m2, m3, m4;
    logic [2:0]   mn;

    ones = '1;
    vecs[0] = '{"zero",     128'd0, 7'd0, 7'd0, 7'd0, 7'd0, 3'd0};
    vecs[1] = '{"sparse4",  bit_at(3) | bit_at(40) | bit_at(77) | bit_at(127),
                7'd3, 7'd40, 7'd77, 7'd127, 3'd4};
    vecs[2] = '{"two",      bit_at(5) | bit_at(100), 7'd5, 7'd100, 7'd0, 7'd0, 3'd2};
    vecs[3] = '{"bit127",   bit_at(127), 7'd127, 7'd0, 7'd0, 7'd0, 3'd1};
    vecs[4] = '{"allones",  ones, 7'd0, 7'd1, 7'd2, 7'd3, 3'd4};
    vecs[5] = '{"top4",     128'hF000_0000_0000_0000_0000_0000_0000_0000,
                7'd124, 7'd125, 7'd126, 7'd127, 3'd4};
    vecs[6] = '{"bit0",     bit_at(0), 7'd0, 7'd0, 7'd0, 7'd0, 3'd1};
    vecs[7] = '{"three",    128'h7, 7'd0, 7'd1, 7'd2, 7'd0, 3'd3};
    vecs[8] = '{"six",      bit_at(10) | bit_at(20) | bit_at(30) | bit_at(40) | bit_at(50) | bit_at(60),
                7'd10, 7'd20, 7'd30, 7'd40, 3'd4};

    // Reset held with a busy input: outputs must stay 0 across edges.
    rst_n = 1'b0;
    data  = ones;
    #1;
    chk_all("rst_async", 7'd0, 7'd0, 7'd0, 7'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst_hold", 7'd0, 7'd0, 7'd0, 7'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    data  = 128'd0;
    #1;
    chk_all("rst_release", 7'd0, 7'd0, 7'd0, 7'd0, 3'd0);

    // Table: drive at negedge, check just after the next rising edge.
    foreach (vecs[i]) begin
      @(negedge clk);
      data = vecs[i].data;
      #1;
      if (i > 0) chk({vecs[i].name, ".latency"}, int'(idx1), int'(vecs[i-1].e1));
      @(posedge clk);
      #1;
      chk_all(vecs[i].name, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4, vecs[i].en);
    end

    // Back-to-back: new word each cycle, outputs track the previous cycle's word.
    @(negedge clk);
    prev = {$urandom, $urandom, $urandom, $urandom};
    data = prev;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      model(prev, m1, m2, m3, m4, mn);
      chk_all($sformatf("b2b%0d", c), m1, m2, m3, m4, mn);
      if (c % 2 == 0)
        prev = {$urandom, $urandom, $urandom, $urandom};
      else
        prev = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom}
             & {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom}
             & {$urandom, $urandom, $urandom, $urandom};
      data = prev;
    end

    // Mid-stream reset between edges while outputs are nonzero.
    @(negedge clk);
    data = vecs[1].data;
    @(posedge clk);
    #1;
    chk_all("pre_mid_rst", 7'd3, 7'd40, 7'd77, 7'd127, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst_async", 7'd0, 7'd0, 7'd0, 7'd0, 3'd0);
    @(posedge clk);
    #1;
    chk_all("mid_rst_hold", 7'd0, 7'd0, 7'd0, 7'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    data  = vecs[2].data;
    #1;
    chk_all("mid_rst_release", 7'd0, 7'd0, 7'd0, 7'd0, 3'd0);
    @(posedge clk);
    #1;
    chk_all("mid_rst_recover", 7'd5, 7'd100, 7'd0, 7'd0, 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
